// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo -- E-stage multiply/divide unit with architectural HI/LO registers.
//
// An mult/multu/div/divu operation computes its 64-bit result at the start
// edge into the pending registers phi/plo. It then holds busy high for a
// fixed number of cycles and commits phi/plo into HI/LO on the last busy edge.
// The hazard unit uses busy to stall md/mt/mf instructions in D.
//
// Build option:
//   MDU_MADD_EN  when defined, codes 9..12 (madd, maddu, msub, msubu) start a
//                multiply-accumulate on {HI,LO}. When undefined, codes 9..15
//                are no-ops.
//
// Parameters:
//   MULT_CYCLES  busy cycles for the multiply family (1..15)
//   DIV_CYCLES   busy cycles for div/divu (1..15)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   MDUOp    in   [3:0] operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 reserved/madd family
//   A        in   [31:0] forwarded rs operand
//   B        in   [31:0] forwarded rt operand
//   req      in   flush of the E-stage instruction (blocks start and mthi/mtlo)
//   start    out  combinational: a multiply/divide is accepted this cycle
//   busy     out  registered: an operation is in flight (state == RUN)
//   MDU_out  out  [31:0] combinational mfhi/mflo result, 0 for other codes
//   HI       out  [31:0] architectural HI
//   LO       out  [31:0] architectural LO
//
// Handshake: start is high only when MDUOp names a multiply/divide, req is low
// and the unit is idle; the operation is accepted on that clock edge. While
// busy is high every further start, mthi and mtlo is dropped, and req never
// aborts an operation that is already in flight.
// -----------------------------------------------------------------------------
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] phi_q,   phi_d;
    logic [31:0] plo_q,   plo_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic is_mul;
    logic is_div;
    logic idle_ok;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (MDUOp)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV,  OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    // Register writes of any kind are only taken when idle and not flushed.
    assign idle_ok = (state_q == S_IDLE) && !req;
    assign start   = (is_mul || is_div) && idle_ok;

    // ------------------------------------------------------------------
    // Arithmetic, evaluated on the current operands every cycle; only the
    // value present at the start edge is captured into phi/plo.
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic        div_ovf;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced by 1 so the divider never sees it; the
    // result is discarded in that case anyway.
    assign div_b   = (B == 32'd0) ? 32'd1 : B;
    // The one signed quotient that does not fit: -2^31 / -1.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else begin
            quo_s = 32'($signed(A) / $signed(div_b));
            rem_s = 32'($signed(A) % $signed(div_b));
        end
        quo_u = A / div_b;
        rem_u = A % div_b;
    end

    logic [63:0] result;

    always_comb begin
        result = {hi_q, lo_q};
        case (MDUOp)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            // Divide by zero reloads the current HI/LO, so commit is a no-op.
            OP_DIV:   result = (B == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
            OP_DIVU:  result = (B == 32'd0) ? {hi_q, lo_q} : {rem_u, quo_u};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
            OP_MSUB:  result = {hi_q, lo_q} - prod_s;
            OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_RUN;
                    cnt_d          = is_div ? DIV_LOAD : MULT_LOAD;
                    {phi_d, plo_d} = result;
                end else if (idle_ok && (MDUOp == OP_MTHI)) begin
                    hi_d = A;
                end else if (idle_ok && (MDUOp == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                // Counter holds the number of busy cycles still to run,
                // including the current one; commit on the last.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDU_out = 32'd0;
        if (MDUOp == OP_MFHI) begin
            MDU_out = hi_q;
        end else if (MDUOp == OP_MFLO) begin
            MDU_out = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo -- directed bench for mdu_hilo (default parameters 5 / 10).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] MDU_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    mdu_hilo #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .MDU_out (MDU_out),
        .HI      (HI),
        .LO      (LO)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write HI (op 7) or LO (op 8) through the mt path.
    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        MDUOp = op;
        A     = val;
        step();
        MDUOp = 4'd0;
        A     = 32'd0;
    endtask

    // Issue a multiply/divide, check busy for exactly n cycles, then result.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MDUOp = op;
        A     = a;
        B     = b;
        #1;
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        step();
        MDUOp = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            step();
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        MDUOp = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        req   = 1'b0;
        repeat (3) step();

        // reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_out", MDU_out, 32'd0);
        reset = 1'b1;
        step();

        // mult / multu: -2 * 3
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

        // div: -7 / 2 -> q=-3, r=-1
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu by zero leaves HI/LO untouched
        mt(4'd7, 32'h11);
        chk("mthi_11", HI, 32'h11);
        mt(4'd8, 32'h22);
        chk("mtlo_22", LO, 32'h22);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);

        // signed overflow and an unsigned divide
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("divu", 4'd4, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999);

        // mthi then mfhi; mflo; no-op code reads zero
        mt(4'd7, 32'h1234_5678);
        MDUOp = 4'd5;
        #1;
        chk("mfhi", MDU_out, 32'h1234_5678);
        MDUOp = 4'd6;
        #1;
        chk("mflo", MDU_out, 32'h1999_9999);
        MDUOp = 4'd0;
        #1;
        chk("mf_none", MDU_out, 32'd0);

        // mtlo with req=1 is dropped
        req = 1'b1;
        mt(4'd8, 32'hDEAD_BEEF);
        req = 1'b0;
        chk("mtlo_req", LO, 32'h1999_9999);

        // req=1 with mult: no start, stays idle
        req   = 1'b1;
        MDUOp = 4'd1;
        A     = 32'd9;
        B     = 32'd9;
        #1;
        chk("req_start", {31'd0, start}, 32'd0);
        step();
        chk("req_busy", {31'd0, busy}, 32'd0);
        chk("req_hi", HI, 32'h1234_5678);
        req   = 1'b0;
        MDUOp = 4'd0;

        // second mult while busy is ignored; first commits on time
        MDUOp = 4'd1;
        A     = 32'd3;
        B     = 32'd4;
        step();
        MDUOp = 4'd0;
        chk("dbl_busy0", {31'd0, busy}, 32'd1);
        step();
        chk("dbl_busy1", {31'd0, busy}, 32'd1);
        MDUOp = 4'd1;
        A     = 32'd5;
        B     = 32'd5;
        #1;
        chk("dbl_start", {31'd0, start}, 32'd0);
        step();
        MDUOp = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("dbl_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("dbl_idle", {31'd0, busy}, 32'd0);
        chk("dbl_hi", HI, 32'd0);
        chk("dbl_lo", LO, 32'd12);

        // req during busy does not abort
        MDUOp = 4'd2;
        A     = 32'd6;
        B     = 32'd7;
        step();
        MDUOp = 4'd0;
        req   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("reqbusy_busy", {31'd0, busy}, 32'd1);
            step();
        end
        req = 1'b0;
        chk("reqbusy_idle", {31'd0, busy}, 32'd0);
        chk("reqbusy_lo", LO, 32'd42);

        // reset mid-operation discards the in-flight result
        mt(4'd7, 32'h55);
        MDUOp = 4'd1;
        A     = 32'hFFFF_FFFE;
        B     = 32'd3;
        step();
        MDUOp = 4'd0;
        step();
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        step();
        reset = 1'b1;
        repeat (8) step();
        chk("midrst_busy_late", {31'd0, busy}, 32'd0);
        chk("midrst_hi_late", HI, 32'd0);
        chk("midrst_lo_late", LO, 32'd0);

`ifdef MDU_MADD_EN
        // maddu: {0, FFFFFFFF} + 1*1 = {1, 0}
        mt(4'd8, 32'hFFFF_FFFF);
        run_op("maddu", 4'd10, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        // code 9 is a no-op
        mt(4'd7, 32'hA5);
        MDUOp = 4'd9;
        A     = 32'd1;
        B     = 32'd1;
        #1;
        chk("op9_start", {31'd0, start}, 32'd0);
        chk("op9_out", MDU_out, 32'd0);
        step();
        MDUOp = 4'd0;
        chk("op9_busy", {31'd0, busy}, 32'd0);
        repeat (6) step();
        chk("op9_hi", HI, 32'hA5);
        chk("op9_lo", LO, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
